// File: rtl/as1802_memif.sv
// AS1802 memory interface: demultiplexes the CPU address bus, sequences SRAM
// read/write strobes and provides a small I/O page with one output and one input port.
module as1802_memif #(
  parameter logic [7:0]  IO_PAGE   = 8'hFF,
  parameter int unsigned WE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  cpu_addr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  input  logic        cpu_tpa,
  input  logic        cpu_mrd_n,
  input  logic        cpu_mwr_n,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        mem_oe_n,
  output logic        mem_we_n,
  output logic [7:0]  port_out,
  input  logic [7:0]  port_in
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         addr_hi_q;
  logic [15:0]        mem_addr_q, mem_addr_d;
  logic [7:0]         wdata_q, wdata_d;
  logic [7:0]         din_q, din_d;
  logic [7:0]         port_out_q, port_out_d;
  logic               oe_n_q, oe_n_d;
  logic               we_n_q, we_n_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wr_io_q, wr_io_d;
  logic               mwr_q;
  logic [7:0]         sync1_q, sync2_q;

  logic               io_c;
  logic [7:0]         addr_lo_c;
  logic               wr_fall_c;
  logic [7:0]         io_rdata_c;

  // Low byte is live on cpu_addr outside TPA; during TPA fall back to the held copy.
  assign addr_lo_c  = cpu_tpa ? mem_addr_q[7:0] : cpu_addr;
  assign io_c       = (addr_hi_q == IO_PAGE);
  assign wr_fall_c  = mwr_q & ~cpu_mwr_n;
  assign mem_addr_d = cpu_tpa ? mem_addr_q : {addr_hi_q, cpu_addr};

  always_comb begin
    case (addr_lo_c)
      8'h00:   io_rdata_c = port_out_q;
      8'h01:   io_rdata_c = sync2_q;
      default: io_rdata_c = 8'hFF;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a write edge wins over a pending read
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_fall_c) begin
          state_d = ST_WRITE;
        end else if (!cpu_mrd_n && cpu_mwr_n) begin
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (cpu_mrd_n) begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (wr_io_q || (cnt_q == '0)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output next-values; strobes default to inactive so OE and WE can never overlap
  always_comb begin
    wdata_d    = wdata_q;
    din_d      = din_q;
    port_out_d = port_out_q;
    oe_n_d     = 1'b1;
    we_n_d     = 1'b1;
    cnt_d      = cnt_q;
    wr_io_d    = wr_io_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_fall_c) begin
          wdata_d = cpu_dout;
          wr_io_d = io_c;
          if (io_c) begin
            if (addr_lo_c == 8'h00) begin
              port_out_d = cpu_dout;
            end
          end else begin
            we_n_d = 1'b0;
            cnt_d  = CNT_W'(WE_CYCLES - 1);
          end
        end else if (!cpu_mrd_n && cpu_mwr_n) begin
          oe_n_d = io_c;
        end
      end
      ST_READ: begin
        din_d = io_c ? io_rdata_c : mem_rdata;
        if (!cpu_mrd_n) begin
          oe_n_d = io_c;
        end
      end
      ST_WRITE: begin
        // Pulse length is fixed once started; cpu_mwr_n is not consulted here
        if (!wr_io_q && (cnt_q != '0)) begin
          we_n_d = 1'b0;
          cnt_d  = cnt_q - CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_hi_q  <= 8'h00;
      mem_addr_q <= 16'h0000;
      wdata_q    <= 8'h00;
      din_q      <= 8'h00;
      port_out_q <= 8'h00;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      cnt_q      <= '0;
      wr_io_q    <= 1'b0;
      mwr_q      <= 1'b1;
      sync1_q    <= 8'h00;
      sync2_q    <= 8'h00;
    end else begin
      if (cpu_tpa) begin
        addr_hi_q <= cpu_addr;
      end
      mem_addr_q <= mem_addr_d;
      wdata_q    <= wdata_d;
      din_q      <= din_d;
      port_out_q <= port_out_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      cnt_q      <= cnt_d;
      wr_io_q    <= wr_io_d;
      mwr_q      <= cpu_mwr_n;
      sync1_q    <= port_in;
      sync2_q    <= sync1_q;
    end
  end

  assign cpu_din   = din_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = wdata_q;
  assign mem_oe_n  = oe_n_q;
  assign mem_we_n  = we_n_q;
  assign port_out  = port_out_q;

endmodule

// File: tb/tb_as1802_memif.sv
// Bench for as1802_memif: two instances (WE_CYCLES=2 and 4) share CPU inputs;
// an SRAM array behind the first instance is compared against an intended-contents table.
module tb_as1802_memif;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  cpu_addr, cpu_dout, port_in;
  logic        cpu_tpa, cpu_mrd_n, cpu_mwr_n;

  logic [7:0]  cpu_din, mem_wdata, mem_rdata, port_out;
  logic [15:0] mem_addr;
  logic        mem_oe_n, mem_we_n;

  logic [7:0]  cpu_din_4, mem_wdata_4, mem_rdata_4, port_out_4;
  logic [15:0] mem_addr_4;
  logic        mem_oe_n_4, mem_we_n_4;

  logic [7:0]  sram    [65536];
  logic [7:0]  ref_mem [65536];
  logic [15:0] written [$];
  logic [7:0]  port_ref;
  logic [7:0]  last_din;

  int vectors = 0;
  int miscompares = 0;

  as1802_memif #(.IO_PAGE(8'hFF), .WE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
    .cpu_tpa(cpu_tpa), .cpu_mrd_n(cpu_mrd_n), .cpu_mwr_n(cpu_mwr_n),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n), .port_out(port_out), .port_in(port_in)
  );

  as1802_memif #(.IO_PAGE(8'hFF), .WE_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_din(cpu_din_4),
    .cpu_tpa(cpu_tpa), .cpu_mrd_n(cpu_mrd_n), .cpu_mwr_n(cpu_mwr_n),
    .mem_addr(mem_addr_4), .mem_wdata(mem_wdata_4), .mem_rdata(mem_rdata_4),
    .mem_oe_n(mem_oe_n_4), .mem_we_n(mem_we_n_4), .port_out(port_out_4), .port_in(port_in)
  );

  assign mem_rdata   = sram[mem_addr];
  assign mem_rdata_4 = sram[mem_addr_4];

  // SRAM stores whatever the first instance strobes in
  always @(posedge clk) begin
    if (!mem_we_n) sram[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Output enable and write enable must never be low together
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("oe_we_excl", 16'(!mem_oe_n && !mem_we_n), 16'd0);
      chk("oe_we_excl4", 16'(!mem_oe_n_4 && !mem_we_n_4), 16'd0);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input logic [15:0] a);
    cpu_tpa  = 1'b1;
    cpu_addr = a[15:8];
    tick();
    cpu_tpa  = 1'b0;
    cpu_addr = a[7:0];
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_addr"},  mem_addr, 16'h0000);
    chk({tag, "_wdata"}, 16'(mem_wdata), 16'h0000);
    chk({tag, "_din"},   16'(cpu_din), 16'h0000);
    chk({tag, "_port"},  16'(port_out), 16'h0000);
    chk({tag, "_oe"},    16'(mem_oe_n), 16'd1);
    chk({tag, "_we"},    16'(mem_we_n), 16'd1);
    chk({tag, "_we4"},   16'(mem_we_n_4), 16'd1);
    chk({tag, "_din4"},  16'(cpu_din_4), 16'h0000);
  endtask

  // One CPU write; hold = cycles cpu_mwr_n stays low, refall = a second edge mid-pulse
  task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int hold,
                          input bit with_rd, input bit refall);
    bit io;
    int lo2, lo4;
    bit oe_seen;
    io = (a[15:8] == 8'hFF);
    lo2 = 0;
    lo4 = 0;
    oe_seen = 1'b0;
    set_addr(a);
    chk("wr_addr", mem_addr, a);
    chk("din_hold_wr", 16'(cpu_din), 16'(last_din));
    cpu_dout  = d;
    cpu_mwr_n = 1'b0;
    if (with_rd) cpu_mrd_n = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (!mem_we_n) lo2++;
      if (!mem_we_n_4) lo4++;
      if (!mem_oe_n || !mem_oe_n_4) oe_seen = 1'b1;
      if (i == 1) chk("wr_wdata", 16'(mem_wdata), 16'(d));
      if (i == hold) begin
        cpu_mwr_n = 1'b1;
        cpu_mrd_n = 1'b1;
      end
      if (refall && i == 2) begin
        cpu_mwr_n = 1'b0;
        cpu_dout  = ~d;
      end
      if (refall && i == 3) cpu_mwr_n = 1'b1;
    end
    chk("we_len2", 16'(lo2), io ? 16'd0 : 16'd2);
    chk("we_len4", 16'(lo4), io ? 16'd0 : 16'd4);
    chk("wr_no_oe", 16'(oe_seen), 16'd0);
    chk("wr_wdata_hold", 16'(mem_wdata), 16'(d));
    if (io) begin
      if (a[7:0] == 8'h00) port_ref = d;
    end else begin
      ref_mem[a] = d;
      written.push_back(a);
    end
    chk("port_out", 16'(port_out), 16'(port_ref));
    chk("port_out4", 16'(port_out_4), 16'(port_ref));
  endtask

  task automatic do_read(input logic [15:0] a, input logic [7:0] exp);
    bit io;
    io = (a[15:8] == 8'hFF);
    set_addr(a);
    chk("din_hold_rd", 16'(cpu_din), 16'(last_din));
    cpu_mrd_n = 1'b0;
    tick();
    chk("rd_oe", 16'(mem_oe_n), 16'(io));
    tick();
    chk("rd_data", 16'(cpu_din), 16'(exp));
    chk("rd_data4", 16'(cpu_din_4), 16'(exp));
    cpu_mrd_n = 1'b1;
    tick();
    chk("rd_oe_off", 16'(mem_oe_n), 16'd1);
    tick();
    tick();
    chk("rd_din_hold", 16'(cpu_din), 16'(exp));
    last_din = exp;
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0]  d;
    rst       = 1'b1;
    cpu_tpa   = 1'b0;
    cpu_addr  = 8'h00;
    cpu_dout  = 8'h00;
    cpu_mrd_n = 1'b1;
    cpu_mwr_n = 1'b1;
    port_in   = 8'h00;
    port_ref  = 8'h00;
    last_din  = 8'h00;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Basic memory write, then overwrite and read back
    do_write(16'h1234, 8'hA5, 2, 1'b0, 1'b0);
    do_write(16'h1234, 8'h5A, 2, 1'b0, 1'b0);
    do_read(16'h1234, 8'h5A);

    // I/O page
    do_write(16'hFF00, 8'h3C, 1, 1'b0, 1'b0);
    do_write(16'hFF05, 8'h99, 1, 1'b0, 1'b0);
    port_in = 8'h81;
    tick();
    tick();
    tick();
    do_read(16'hFF01, 8'h81);
    do_read(16'hFF07, 8'hFF);
    do_read(16'hFF00, 8'h3C);

    // Simultaneous strobes: write wins, OE stays high
    do_write(16'h4321, 8'hC3, 1, 1'b1, 1'b0);
    do_read(16'h4321, 8'hC3);

    // Early release plus an ignored second falling edge during the pulse
    do_write(16'h5555, 8'h11, 1, 1'b0, 1'b1);
    do_read(16'h5555, 8'h11);

    // Randomized memory traffic, read back against intended contents
    for (int k = 0; k < 12; k++) begin
      a = {8'($urandom_range(0, 254)), 8'($urandom)};
      d = 8'($urandom);
      do_write(a, d, int'($urandom_range(1, 3)), 1'b0, 1'b0);
    end
    foreach (written[i]) begin
      do_read(written[i], ref_mem[written[i]]);
    end

    // Randomized I/O traffic
    for (int k = 0; k < 4; k++) begin
      d = 8'($urandom);
      a = {8'hFF, 8'($urandom_range(0, 1) == 0 ? 0 : $urandom_range(1, 255))};
      do_write(a, d, 1, 1'b0, 1'b0);
      do_read(16'hFF00, port_ref);
      port_in = 8'($urandom);
      tick();
      tick();
      tick();
      do_read(16'hFF01, port_in);
      do_read({8'hFF, 8'($urandom_range(2, 255))}, 8'hFF);
    end

    // Reset asserted during the second cycle of a write pulse
    set_addr(16'h2222);
    cpu_dout  = 8'h77;
    cpu_mwr_n = 1'b0;
    tick();
    chk("rst_mid_we_low", 16'(mem_we_n), 16'd0);
    cpu_mwr_n = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    check_reset_outputs("rst_mid");
    port_ref = 8'h00;
    last_din = 8'h00;
    tick();
    rst = 1'b0;
    tick();
    do_write(16'h0F0F, 8'hE1, 2, 1'b0, 1'b0);
    do_read(16'h0F0F, 8'hE1);
    do_read(16'hFF00, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/as1802_memif.md
AS1802_MEMIF -- requirements
Module: as1802_memif

Interface
REQ-001 SHALL have parameter IO_PAGE, default 8'hFF: high address byte selecting the on-block I/O page.
REQ-002 SHALL have parameter WE_CYCLES, default 2, legal range 1..15: width of the memory write strobe in clk cycles.
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port cpu_addr, input, 8: multiplexed CPU address byte (high byte while cpu_tpa=1, low byte otherwise).
REQ-006 SHALL have port cpu_dout, input, 8: CPU write data.
REQ-007 SHALL have port cpu_din, output, 8: read data returned to the CPU.
REQ-008 SHALL have port cpu_tpa, input, 1: active-high timing pulse that qualifies the high address byte.
REQ-009 SHALL have port cpu_mrd_n, input, 1: active-low memory read.
REQ-010 SHALL have port cpu_mwr_n, input, 1: active-low memory write.
REQ-011 SHALL have port mem_addr, output, 16: registered demultiplexed address to external SRAM.
REQ-012 SHALL have port mem_wdata, output, 8: registered write data to SRAM.
REQ-013 SHALL have port mem_rdata, input, 8: SRAM read data.
REQ-014 SHALL have port mem_oe_n, output, 1: active-low SRAM output enable.
REQ-015 SHALL have port mem_we_n, output, 1: active-low SRAM write enable.
REQ-016 SHALL have port port_out, output, 8: I/O page output register.
REQ-017 SHALL have port port_in, input, 8: asynchronous input pins.

Function
REQ-018 SHALL load addr_hi from cpu_addr on every rising clk edge where cpu_tpa=1.
REQ-019 SHALL register mem_addr <= {addr_hi, cpu_addr} on every cycle where cpu_tpa=0, and hold mem_addr while cpu_tpa=1.
REQ-020 SHALL classify an access as I/O when addr_hi==IO_PAGE, and as memory otherwise.
REQ-021 SHALL implement FSM states IDLE, READ and WRITE.
REQ-022 SHALL go IDLE->WRITE on a cpu_mwr_n 1->0 transition, detected against a registered copy of cpu_mwr_n.
REQ-023 SHALL latch mem_wdata <= cpu_dout in the cycle the IDLE->WRITE transition is taken.
REQ-024 SHALL, in WRITE for a memory access, drive mem_we_n=0 for exactly WE_CYCLES cycles, then return to IDLE.
REQ-025 SHALL let a WRITE pulse run its full length even if cpu_mwr_n rises early.
REQ-026 SHALL ignore any new cpu_mwr_n falling edge that occurs while in WRITE.
REQ-027 SHALL, for an I/O write, perform no SRAM strobe: offset 8'h00 loads port_out <= cpu_dout in one cycle, other offsets are discarded, and the FSM returns to IDLE.
REQ-028 SHALL go IDLE->READ when cpu_mrd_n=0 and cpu_mwr_n=1, and return READ->IDLE when cpu_mrd_n=1.
REQ-029 SHALL, in READ for a memory access, hold mem_oe_n=0 and register cpu_din <= mem_rdata every cycle, giving 1-cycle latency.
REQ-030 SHALL, in READ for an I/O access, register cpu_din as follows: offset 8'h00 gives port_out, offset 8'h01 gives synchronized port_in, all other offsets give 8'hFF.
REQ-031 SHALL give write priority over read: if cpu_mrd_n=0 and cpu_mwr_n=0 together, take WRITE and hold mem_oe_n=1.
REQ-032 SHALL never assert mem_oe_n=0 and mem_we_n=0 in the same cycle.
REQ-033 SHALL synchronize port_in through two flops before use.
REQ-034 SHALL keep cpu_din unchanged outside READ.

Reset
REQ-035 SHALL, on rst=1 at a clk edge, set: FSM=IDLE, addr_hi=0, mem_addr=0, mem_wdata=0, cpu_din=0, port_out=0, mem_oe_n=1, mem_we_n=1, write counter=0, synchronizers=0, registered cpu_mwr_n=1.
REQ-036 SHALL, when rst asserts mid-WRITE or mid-READ, deassert both strobes at that edge with no further SRAM access.

Verification
REQ-037 SHALL cover memory write: TPA with 8'h12, low byte 8'h34, cpu_dout=8'hA5, cpu_mwr_n falls -> mem_addr=16'h1234, mem_wdata=8'hA5, mem_we_n low for exactly 2 cycles.
REQ-038 SHALL cover memory read: address 16'h1234, mem_rdata=8'h5A, cpu_mrd_n=0 -> mem_oe_n=0 and cpu_din=8'h5A one cycle later.
REQ-039 SHALL cover I/O: write 8'h3C to 16'hFF00 -> port_out=8'h3C and mem_we_n stays 1; read 16'hFF01 with port_in=8'h81 held for 3 cycles -> cpu_din=8'h81; read 16'hFF07 -> cpu_din=8'hFF.
REQ-040 SHALL cover simultaneous strobes: cpu_mrd_n=0 and cpu_mwr_n=0 together -> WRITE taken, mem_oe_n=1 throughout.
REQ-041 SHALL cover early release: cpu_mwr_n low for 1 cycle with WE_CYCLES=4 -> mem_we_n low for exactly 4 cycles.
REQ-042 SHALL cover reset mid-write: rst asserted on the second cycle of the WE pulse -> mem_we_n=1 at that edge and all outputs at reset values.
